// File: rtl/pipe_spawner_if.sv
// pipe_spawner_if
// Groups the spawn/retire handshake between the pipe spawner and the rest of
// the game datapath (collision logic, pipe animator, score display).
//
// Signals:
//   start        level, starts/restarts a game
//   gameOver     level, collision reported by the collision logic
//   endOfMapPipe one-cycle pulse from the animator when its pipe leaves the map
//   spawnPipe    one-cycle spawn request toward the animator (mouse1)
//   pointY       gap centre Y for the pipe being spawned
//   score        pipes passed, saturating
//   running      game in progress (DELAY, SPAWN or WAIT)
//   timeoutFlag  sticky, a pipe was lost while in flight
//
// Modports:
//   master  the spawner side (drives spawnPipe, pointY, score, running, timeoutFlag)
//   slave   the environment side (drives start, gameOver, endOfMapPipe)
interface pipe_spawner_if;
    logic       start;
    logic       gameOver;
    logic       endOfMapPipe;
    logic       spawnPipe;
    logic [9:0] pointY;
    logic [9:0] score;
    logic       running;
    logic       timeoutFlag;

    modport master (
        input  start,
        input  gameOver,
        input  endOfMapPipe,
        output spawnPipe,
        output pointY,
        output score,
        output running,
        output timeoutFlag
    );

    modport slave (
        output start,
        output gameOver,
        output endOfMapPipe,
        input  spawnPipe,
        input  pointY,
        input  score,
        input  running,
        input  timeoutFlag
    );
endinterface

// File: rtl/pipe_spawner.sv
// pipe_spawner
// Issuing end of the pipe spawn/retire handshake. Decides when a new pipe
// enters the map and at which gap height, counts pipes that leave the map and
// flags pipes that never come back.
//
// Ports:
//   animationCLOCK  animation tick clock, all state changes on its rising edge
//   reset           asynchronous, active-high
//   bus             pipe_spawner_if.master (see the interface for signal list)
//
// All outputs are registered; nothing on the bus has a combinational path
// from any input.
module pipe_spawner #(
    parameter int SPAWN_DELAY = 40,
    parameter int TIMEOUT     = 2000,
    parameter int Y_MIN       = 60,
    parameter int Y_RANGE     = 360,
    parameter int SCORE_MAX   = 999
) (
    input  logic           animationCLOCK,
    input  logic           reset,
    pipe_spawner_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DELAY   = 3'd1,
        SPAWN   = 3'd2,
        WAIT    = 3'd3,
        STOPPED = 3'd4
    } state_t;

    localparam logic [15:0] DELAY_LAST   = 16'(SPAWN_DELAY - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [8:0]  Y_RANGE_W    = 9'(Y_RANGE);
    localparam logic [9:0]  Y_MIN_W      = 10'(Y_MIN);
    localparam logic [9:0]  Y_RESET      = 10'(Y_MIN + Y_RANGE / 2);
    localparam logic [9:0]  SCORE_MAX_W  = 10'(SCORE_MAX);
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;

    state_t      state;
    state_t      state_nx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
    logic [15:0] lfsr;
    logic        spawn_q;
    logic        spawn_nx;
    logic [9:0]  point_q;
    logic [9:0]  point_nx;
    logic [9:0]  score_q;
    logic [9:0]  score_nx;
    logic        tflag_q;
    logic        tflag_nx;
    logic        running_q;
    logic        running_nx;

    // Fibonacci taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return {l[14:0], fb};
    endfunction

    // Folds a 9-bit random value into Y_RANGE gap centres. Since Y_RANGE is at
    // least 256, one conditional subtract always lands inside the range.
    function automatic logic [9:0] gap_centre(input logic [8:0] raw);
        logic [8:0] r;
        r = raw;
        if (r >= Y_RANGE_W) begin
            r = r - Y_RANGE_W;
        end
        return Y_MIN_W + {1'b0, r};
    endfunction

    function automatic logic [9:0] score_inc_sat(input logic [9:0] s);
        return (s >= SCORE_MAX_W) ? SCORE_MAX_W : s + 10'd1;
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        spawn_nx = 1'b0;
        point_nx = point_q;
        score_nx = score_q;
        tflag_nx = tflag_q;

        // gameOver wins over everything else arriving in the same cycle.
        if (bus.gameOver) begin
            state_nx = STOPPED;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE, STOPPED: begin
                    if (bus.start) begin
                        state_nx = DELAY;
                        cnt_nx   = '0;
                        score_nx = '0;
                        tflag_nx = 1'b0;
                    end
                end
                DELAY: begin
                    if (cnt == DELAY_LAST) begin
                        state_nx = SPAWN;
                        cnt_nx   = '0;
                        spawn_nx = 1'b1;
                        point_nx = gap_centre(lfsr[8:0]);
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
                SPAWN: begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                end
                WAIT: begin
                    if (bus.endOfMapPipe) begin
                        state_nx = DELAY;
                        cnt_nx   = '0;
                        score_nx = score_inc_sat(score_q);
                    end else if (cnt == TIMEOUT_LAST) begin
                        // Pipe never came back; reschedule without scoring.
                        state_nx = DELAY;
                        cnt_nx   = '0;
                        tflag_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end

        running_nx = (state_nx == DELAY) || (state_nx == SPAWN) || (state_nx == WAIT);
    end

    always_ff @(posedge animationCLOCK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lfsr      <= LFSR_SEED;
            spawn_q   <= 1'b0;
            point_q   <= Y_RESET;
            score_q   <= '0;
            tflag_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            // Free-running in every state so gap heights follow player timing.
            lfsr      <= lfsr_step(lfsr);
            spawn_q   <= spawn_nx;
            point_q   <= point_nx;
            score_q   <= score_nx;
            tflag_q   <= tflag_nx;
            running_q <= running_nx;
        end
    end

    assign bus.spawnPipe   = spawn_q;
    assign bus.pointY      = point_q;
    assign bus.score       = score_q;
    assign bus.running     = running_q;
    assign bus.timeoutFlag = tflag_q;

endmodule

// File: tb/tb_pipe_spawner.sv
// tb_pipe_spawner
// Directed bench for pipe_spawner. Two instances share the same stimulus:
// dut (TIMEOUT=100) exercises scoring, saturation, game over and reset;
// dut_to (TIMEOUT=20) exercises the lost-pipe timeout.
module tb_pipe_spawner;

    localparam int SD       = 4;
    localparam int TO_MAIN  = 100;
    localparam int TO_SHORT = 20;
    localparam int YMIN     = 60;
    localparam int YRANGE   = 360;
    localparam int SMAX     = 999;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic start     = 1'b0;
    logic game_over = 1'b0;
    logic eomp      = 1'b0;

    always #5 clk = ~clk;

    pipe_spawner_if bus0 ();
    pipe_spawner_if bus1 ();

    assign bus0.start        = start;
    assign bus0.gameOver     = game_over;
    assign bus0.endOfMapPipe = eomp;
    assign bus1.start        = start;
    assign bus1.gameOver     = game_over;
    assign bus1.endOfMapPipe = eomp;

    pipe_spawner #(
        .SPAWN_DELAY(SD), .TIMEOUT(TO_MAIN), .Y_MIN(YMIN), .Y_RANGE(YRANGE), .SCORE_MAX(SMAX)
    ) dut (
        .animationCLOCK(clk), .reset(rst), .bus(bus0)
    );

    pipe_spawner #(
        .SPAWN_DELAY(SD), .TIMEOUT(TO_SHORT), .Y_MIN(YMIN), .Y_RANGE(YRANGE), .SCORE_MAX(SMAX)
    ) dut_to (
        .animationCLOCK(clk), .reset(rst), .bus(bus1)
    );

    // Reference LFSR; m_prev is the value the DUT sees just before each edge.
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] exp_gap(input logic [15:0] l);
        int r;
        r = int'(l[8:0]);
        if (r >= YRANGE) r = r - YRANGE;
        return 10'(YMIN + r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until the selected instance shows spawnPipe; k = edges taken, -1 on budget expiry.
    task automatic wait_spawn(input int sel, output int k);
        logic seen;
        k = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            seen = (sel == 0) ? bus0.spawnPipe : bus1.spawnPipe;
            if (seen) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic check_gap(input string tag);
        check({tag, "_y"}, 32'(bus0.pointY), 32'(exp_gap(m_prev)));
        check({tag, "_range"}, 32'((bus0.pointY >= 10'(YMIN)) && (bus0.pointY <= 10'(YMIN + YRANGE - 1))), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_spawn"},   32'(bus0.spawnPipe),   32'd0);
        check({tag, "_pointY"},  32'(bus0.pointY),      32'd240);
        check({tag, "_score"},   32'(bus0.score),       32'd0);
        check({tag, "_running"}, 32'(bus0.running),     32'd0);
        check({tag, "_tflag"},   32'(bus0.timeoutFlag), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bad;
        int spawns;

        // Reset state and first LFSR step
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_vals("reset");
        tick();
        check("lfsr_first_step", 32'(dut.lfsr), 32'h59C3);

        // First spawn SD edges after start
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_running", 32'(bus0.running), 32'd1);
        wait_spawn(0, k);
        check("first_spawn_lat", 32'(k), 32'(SD));
        check_gap("first_spawn");
        tick();
        check("spawn_one_cycle", 32'(bus0.spawnPipe), 32'd0);
        check("wait_running", 32'(bus0.running), 32'd1);

        // Ten retire pulses, each 50 cycles after its spawn
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? 48 : 49) tick();
            eomp = 1'b1;
            tick();
            eomp = 1'b0;
            check("pulse_score", 32'(bus0.score), 32'(i + 1));
            wait_spawn(0, k);
            check("pulse_spawn_lat", 32'(k), 32'(SD));
            check_gap("pulse_spawn");
        end
        check("ten_score", 32'(bus0.score), 32'd10);
        check("ten_tflag", 32'(bus0.timeoutFlag), 32'd0);

        // gameOver and retire pulse together in WAIT
        tick();
        game_over = 1'b1;
        eomp      = 1'b1;
        tick();
        eomp = 1'b0;
        check("go_score_frozen", 32'(bus0.score), 32'd10);
        check("go_running", 32'(bus0.running), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        spawns = 0;
        repeat (10) begin
            tick();
            spawns += int'(bus0.spawnPipe);
        end
        check("go_start_ignored", 32'(bus0.running), 32'd0);
        game_over = 1'b0;
        repeat (10) begin
            tick();
            spawns += int'(bus0.spawnPipe);
        end
        check("go_no_spawn", 32'(spawns), 32'd0);
        check("go_still_stopped", 32'(bus0.running), 32'd0);

        // Restart from STOPPED
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_score", 32'(bus0.score), 32'd0);
        check("restart_running", 32'(bus0.running), 32'd1);
        wait_spawn(0, k);
        check("restart_spawn_lat", 32'(k), 32'(SD));
        check_gap("restart_spawn");

        // Drive score to SCORE_MAX, then one more pulse
        bad = 0;
        for (int i = 0; i < SMAX; i++) begin
            tick();
            eomp = 1'b1;
            tick();
            eomp = 1'b0;
            wait_spawn(0, k);
            if (k != SD) bad++;
        end
        check("sat_loop_lat_bad", 32'(bad), 32'd0);
        check("sat_reach", 32'(bus0.score), 32'(SMAX));
        tick();
        eomp = 1'b1;
        tick();
        eomp = 1'b0;
        check("sat_hold", 32'(bus0.score), 32'(SMAX));
        wait_spawn(0, k);
        check("sat_spawn_lat", 32'(k), 32'(SD));

        // Asynchronous reset between edges during DELAY
        tick();
        eomp = 1'b1;
        tick();
        eomp = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        #1 rst = 1'b0;
        spawns = 0;
        repeat (12) begin
            tick();
            spawns += int'(bus0.spawnPipe);
        end
        check("rst_no_spawn", 32'(spawns), 32'd0);
        check("rst_idle", 32'(bus0.running), 32'd0);

        // Lost pipe on the short-timeout instance
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_spawn(1, k);
        check("to_first_spawn_lat", 32'(k), 32'(SD));
        tick();
        repeat (TO_SHORT - 1) tick();
        check("to_not_yet", 32'(bus1.timeoutFlag), 32'd0);
        tick();
        check("to_flag", 32'(bus1.timeoutFlag), 32'd1);
        check("to_score", 32'(bus1.score), 32'd0);
        check("to_running", 32'(bus1.running), 32'd1);
        check("main_no_timeout", 32'(bus0.timeoutFlag), 32'd0);
        wait_spawn(1, k);
        check("to_respawn_lat", 32'(k), 32'(SD));

        // Sticky flag survives game over, cleared by the next start
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        check("to_flag_sticky", 32'(bus1.timeoutFlag), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_flag_cleared", 32'(bus1.timeoutFlag), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
